lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store responder for the execute stage's memory-control encodings: MemWrite (sb/sh/sw) and MemRead (lw/lb/lh/lbu/lhu).
- Accepts one core memory request at a time and performs it as a single word-aligned transaction on the data bus, using a req/ack handshake with timeout.
- Returns load data to writeback, byte/half extracted and sign- or zero-extended.
- Sits between the core's memory stage and the data RAM/bus fabric.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUS-state cycles waiting for bus_ack before aborting with error; 0 disables the timeout.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_load  in  1  request is a load.
- req_mem_write  in  2  00 none, 01 sb, 10 sh, 11 sw.
- req_mem_read  in  3  load type when req_load=1: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned, illegal or timeout.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  completion; sampled only in BUS.
- bus_rdata  in  32  read word; valid in the bus_ack cycle.

Behaviour:
- State machine IDLE -> BUS -> RESP -> IDLE; an error path goes IDLE -> RESP directly.
- req_ready = (state == IDLE). A request is accepted on req_valid & req_ready; all req_* fields are latched on acceptance.
- Reset: state IDLE, counter 0; bus_req, bus_we, resp_valid, resp_err = 0; bus_addr, bus_be, bus_wdata, resp_rdata = 0.
  - Reset mid-transaction aborts it: no resp_valid, and bus_req drops on the next edge.
- Illegal request: req_load=1 with req_mem_write!=00, req_load=0 with req_mem_write=00, or req_mem_read in 101–111. Goes to RESP with resp_err=1 and no bus activity.
- Alignment rules:
  - sh, lh, lhu require addr[0]=0.
  - sw, lw require addr[1:0]=00.
  - sb, lb, lbu are always aligned.
  - Misaligned requests go to RESP with resp_err=1 and no bus activity.
- Stores:
  - bus_we=1.
  - sb: bus_be = 4'b0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - sh: bus_be = addr[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - sw: bus_be = 1111; bus_wdata = wdata.
- Loads:
  - bus_we=0, bus_be=1111, bus_wdata=0.
  - On ack, select byte bus_rdata[8*addr[1:0] +: 8] or half bus_rdata[16*addr[1] +: 16].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
- BUS state:
  - bus_req and all bus_* outputs stay stable until the bus_ack cycle.
  - On bus_ack: go to RESP; the next cycle has bus_req=0.
  - Load data is registered into resp_rdata on the ack edge.
- Timeout:
  - The counter increments each BUS cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack: go to RESP with resp_err=1, resp_rdata=0, bus_req dropped.
  - Ack in that same cycle wins: completes normally.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The counter clears on entering BUS.
- Latency, aligned access with ack in the first BUS cycle: accept at edge N; bus_req high in cycle N+1; resp_valid in cycle N+2; req_ready high again in cycle N+3.
- Latency, error path: resp_valid in the cycle after acceptance.
- bus_ack outside BUS is ignored. req_valid while not ready is ignored; the requester holds it.

Test Plan:
1. sb addr=0x1003, wdata=0x000000A5, ack after 2 cycles -> bus_addr=0x1000, be=1000, wdata=0xA5A5A5A5, we=1; resp_valid one cycle, err=0, rdata=0.
2. Byte loads at addr=0x2001 with bus_rdata=0x1234F600: lb -> rdata=0xFFFFFFF6; lbu -> 0x000000F6. Half loads at addr=0x2002 with bus_rdata=0x8001xxxx: lh -> 0xFFFF8001; lhu -> 0x00008001.
3. Misaligned cases: lw addr=0x3002 and sh addr=0x3001 -> no bus_req; resp_valid next cycle with err=1.
4. Timeout with TIMEOUT_CYCLES=4: sw, no ack -> bus_req high for exactly 4 cycles, then resp err=1. Repeat with ack in cycle 4 -> err=0.
5. Reset raised in the middle of the BUS state -> bus_req=0 after the edge, no resp_valid, req_ready=1. The next lw then completes normally.
6. Illegal and back-to-back cases: req_load=1 with mem_write=11 -> err=1, no bus. Back-to-back requests with req_valid held -> second accepted only when req_ready=1, one resp per request.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store responder: one core memory request at a time, issued as a single
// word-aligned req/ack bus transaction with lane steering, load extension and timeout.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [1:0]        req_mem_write,
    input  logic [2:0]        req_mem_read,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    localparam logic [2:0] MR_LW   = 3'b000;
    localparam logic [2:0] MR_LB   = 3'b001;
    localparam logic [2:0] MR_LH   = 3'b010;
    localparam logic [2:0] MR_LBU  = 3'b011;
    localparam logic [2:0] MR_LHU  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              lat_load;
    logic              lat_load_nxt;
    logic [2:0]        lat_mem_read;
    logic [2:0]        lat_mem_read_nxt;
    logic [1:0]        lat_addr_lo;
    logic [1:0]        lat_addr_lo_nxt;

    logic              req_ready_nxt;
    logic              resp_valid_nxt;
    logic [31:0]       resp_rdata_nxt;
    logic              resp_err_nxt;
    logic              bus_req_nxt;
    logic              bus_we_nxt;
    logic [ADDR_W-1:0] bus_addr_nxt;
    logic [3:0]        bus_be_nxt;
    logic [31:0]       bus_wdata_nxt;

    logic              accept;
    logic              req_illegal;
    logic              req_misaligned;
    logic              req_fault;
    logic              timeout_hit;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    assign accept      = req_valid & req_ready;
    assign req_fault   = req_illegal | req_misaligned;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));

    // Request legality and natural-alignment check
    always_comb begin
        req_illegal    = req_load ? (req_mem_write != MW_NONE) : (req_mem_write == MW_NONE);
        req_misaligned = 1'b0;
        if (req_mem_read > MR_LHU) begin
            req_illegal = 1'b1;
        end
        if (req_load) begin
            case (req_mem_read)
                MR_LW:         req_misaligned = (req_addr[1:0] != 2'b00);
                MR_LH, MR_LHU: req_misaligned = req_addr[0];
                default:       req_misaligned = 1'b0;
            endcase
        end else begin
            case (req_mem_write)
                MW_SH:   req_misaligned = req_addr[0];
                MW_SW:   req_misaligned = (req_addr[1:0] != 2'b00);
                default: req_misaligned = 1'b0;
            endcase
        end
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        case (req_mem_write)
            MW_SB: begin
                st_be    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            MW_SH: begin
                st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    // Load lane selection and extension from the returned bus word
    always_comb begin
        ld_byte = bus_rdata[8*lat_addr_lo +: 8];
        ld_half = bus_rdata[16*lat_addr_lo[1] +: 16];
        case (lat_mem_read)
            MR_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            MR_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            MR_LBU:  ld_data = {24'h0, ld_byte};
            MR_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_fault ? RESP : BUS;
                end
            end
            BUS: begin
                if (bus_ack || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; bus fields hold through BUS
    always_comb begin
        req_ready_nxt    = (state_nxt == IDLE);
        bus_req_nxt      = (state_nxt == BUS);
        resp_valid_nxt   = (state_nxt == RESP);
        resp_err_nxt     = 1'b0;
        resp_rdata_nxt   = resp_rdata;
        bus_we_nxt       = bus_we;
        bus_addr_nxt     = bus_addr;
        bus_be_nxt       = bus_be;
        bus_wdata_nxt    = bus_wdata;
        cnt_nxt          = cnt;
        lat_load_nxt     = lat_load;
        lat_mem_read_nxt = lat_mem_read;
        lat_addr_lo_nxt  = lat_addr_lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    lat_load_nxt     = req_load;
                    lat_mem_read_nxt = req_mem_read;
                    lat_addr_lo_nxt  = req_addr[1:0];
                    resp_rdata_nxt   = 32'h0;
                    cnt_nxt          = '0;
                    if (req_fault) begin
                        resp_err_nxt = 1'b1;
                    end else begin
                        bus_we_nxt    = ~req_load;
                        bus_addr_nxt  = {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be_nxt    = req_load ? 4'b1111 : st_be;
                        bus_wdata_nxt = req_load ? 32'h0 : st_wdata;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    resp_rdata_nxt = lat_load ? ld_data : 32'h0;
                end else if (timeout_hit) begin
                    resp_err_nxt   = 1'b1;
                    resp_rdata_nxt = 32'h0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                resp_err_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= 4'h0;
            bus_wdata    <= 32'h0;
            cnt          <= '0;
            lat_load     <= 1'b0;
            lat_mem_read <= 3'h0;
            lat_addr_lo  <= 2'h0;
        end else begin
            req_ready    <= req_ready_nxt;
            resp_valid   <= resp_valid_nxt;
            resp_rdata   <= resp_rdata_nxt;
            resp_err     <= resp_err_nxt;
            bus_req      <= bus_req_nxt;
            bus_we       <= bus_we_nxt;
            bus_addr     <= bus_addr_nxt;
            bus_be       <= bus_be_nxt;
            bus_wdata    <= bus_wdata_nxt;
            cnt          <= cnt_nxt;
            lat_load     <= lat_load_nxt;
            lat_mem_read <= lat_mem_read_nxt;
            lat_addr_lo  <= lat_addr_lo_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: responses are checked against a scoreboard
// queue filled from a reference model when each request is driven.
module tb_lsu_mem_port;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TO     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [1:0]        req_mem_write;
    logic [2:0]        req_mem_read;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    lsu_mem_port #(.TIMEOUT_CYCLES(TO), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_mem_write(req_mem_write), .req_mem_read(req_mem_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        resp_t item;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
            item = exp_q.pop_front();
            check({tag, "_rdata"}, resp_rdata, item.rdata);
            check({tag, "_err"}, 32'(resp_err), 32'(item.err));
        end
    endtask

    // Reference behaviour for one request against a given bus read word
    function automatic void model(input logic ld, input logic [1:0] mw, input logic [2:0] mr,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rd, output logic [3:0] be,
                                  output logic [31:0] bwd, output logic [31:0] rdata,
                                  output logic err);
        logic [7:0]  b;
        logic [15:0] h;
        err = (ld && mw != 2'b00) || (!ld && mw == 2'b00) || (mr > 3'd4);
        if (ld && mr == 3'd0 && addr[1:0] != 2'b00) err = 1'b1;
        if (ld && (mr == 3'd2 || mr == 3'd4) && addr[0]) err = 1'b1;
        if (!ld && mw == 2'd2 && addr[0]) err = 1'b1;
        if (!ld && mw == 2'd3 && addr[1:0] != 2'b00) err = 1'b1;
        b     = 8'(rd >> (8 * addr[1:0]));
        h     = 16'(rd >> (addr[1] ? 16 : 0));
        be    = 4'hF;
        bwd   = 32'h0;
        rdata = 32'h0;
        if (!ld) begin
            case (mw)
                2'd1: begin
                    case (addr[1:0])
                        2'd0:    be = 4'b0001;
                        2'd1:    be = 4'b0010;
                        2'd2:    be = 4'b0100;
                        default: be = 4'b1000;
                    endcase
                    bwd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                end
                2'd2: begin
                    be  = addr[1] ? 4'b1100 : 4'b0011;
                    bwd = {wd[15:0], wd[15:0]};
                end
                default: bwd = wd;
            endcase
        end else begin
            case (mr)
                3'd1:    rdata = {{24{b[7]}}, b};
                3'd2:    rdata = {{16{h[15]}}, h};
                3'd3:    rdata = {24'h0, b};
                3'd4:    rdata = {16'h0, h};
                default: rdata = rd;
            endcase
        end
        if (err) rdata = 32'h0;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
    endtask

    // ack_at: bus cycle (1-based) that returns ack; 0 = never ack
    task automatic txn(input string tag, input logic ld, input logic [1:0] mw,
                       input logic [2:0] mr, input logic [31:0] addr, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rd);
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_bcyc;
        int          bcyc;
        bit          got;
        model(ld, mw, mr, addr, wd, rd, e_be, e_wd, e_rd, e_err);
        e_bcyc = e_err ? 0 : ((ack_at == 0) ? int'(TO) : ack_at);
        if (!e_err && ack_at == 0) begin
            e_err = 1'b1;
            e_rd  = 32'h0;
        end
        wait_ready(tag);
        req_valid     = 1'b1;
        req_load      = ld;
        req_mem_write = mw;
        req_mem_read  = mr;
        req_addr      = addr;
        req_wdata     = wd;
        exp_q.push_back('{rdata: e_rd, err: e_err});
        @(negedge clk);
        req_valid = 1'b0;
        got  = 1'b0;
        bcyc = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (bus_req) begin
                bcyc++;
                check({tag, "_bus_addr"}, bus_addr, {addr[31:2], 2'b00});
                check({tag, "_bus_be"}, 32'(bus_be), 32'(e_be));
                check({tag, "_bus_wdata"}, bus_wdata, e_wd);
                check({tag, "_bus_we"}, 32'(bus_we), 32'(!ld));
                if (bcyc == ack_at) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd;
                end
            end
            if (resp_valid) begin
                got = 1'b1;
                pop_check(tag);
                check({tag, "_latency"}, 32'(i), 32'(e_bcyc + 1));
                check({tag, "_bus_cycles"}, 32'(bcyc), 32'(e_bcyc));
            end
            @(negedge clk);
            bus_ack = 1'b0;
        end
        if (!got) begin
            check({tag, "_no_resp"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [3:0]  m_be;
        logic [31:0] m_wd;
        logic [31:0] m_rd;
        logic        m_err;
        int          nresp;
        int          ready_at;
        int          b_at;

        reset = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_mem_write = 2'b00; req_mem_read = 3'b000;
        req_addr = '0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        txn("sb",       1'b0, 2'b01, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2, 32'h0);
        txn("lb",       1'b1, 2'b00, 3'b001, 32'h0000_2001, 32'h0, 1, 32'h1234_F600);
        txn("lbu",      1'b1, 2'b00, 3'b011, 32'h0000_2001, 32'h0, 3, 32'h1234_F600);
        txn("lh",       1'b1, 2'b00, 3'b010, 32'h0000_2002, 32'h0, 1, 32'h8001_7777);
        txn("lhu",      1'b1, 2'b00, 3'b100, 32'h0000_2002, 32'h0, 2, 32'h8001_7777);
        txn("lw",       1'b1, 2'b00, 3'b000, 32'h0000_2004, 32'h0, 1, 32'hDEAD_BEEF);
        txn("sh_hi",    1'b0, 2'b10, 3'b000, 32'h0000_2002, 32'h1234_BEEF, 1, 32'h0);
        txn("lw_mis",   1'b1, 2'b00, 3'b000, 32'h0000_3002, 32'h0, 1, 32'h0);
        txn("sh_mis",   1'b0, 2'b10, 3'b000, 32'h0000_3001, 32'h0000_1234, 1, 32'h0);
        txn("sw_to",    1'b0, 2'b11, 3'b000, 32'h0000_4000, 32'hCAFE_F00D, 0, 32'h0);
        txn("sw_ack4",  1'b0, 2'b11, 3'b000, 32'h0000_4000, 32'hCAFE_F00D, 4, 32'h0);
        txn("ill_ldst", 1'b1, 2'b11, 3'b000, 32'h0000_5000, 32'h0, 1, 32'h0);
        txn("ill_none", 1'b0, 2'b00, 3'b000, 32'h0000_5000, 32'h0, 1, 32'h0);
        txn("ill_mr",   1'b1, 2'b00, 3'b101, 32'h0000_5000, 32'h0, 1, 32'h0);

        // Reset during BUS aborts the transaction silently
        wait_ready("rst_mid");
        req_valid = 1'b1; req_load = 1'b1; req_mem_write = 2'b00; req_mem_read = 3'b000;
        req_addr = 32'h0000_6000;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_bus_req_on", 32'(bus_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_bus_req_off", 32'(bus_req), 32'd0);
        check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_no_resp2", 32'(resp_valid), 32'd0);
        txn("lw_after_rst", 1'b1, 2'b00, 3'b000, 32'h0000_6000, 32'h0, 1, 32'h0BAD_F00D);

        // Back-to-back: second request held until ready returns
        wait_ready("b2b");
        req_valid = 1'b1; req_load = 1'b0; req_mem_write = 2'b11; req_mem_read = 3'b000;
        req_addr = 32'h0000_7000; req_wdata = 32'h1122_3344;
        model(1'b0, 2'b11, 3'b000, 32'h0000_7000, 32'h1122_3344, 32'h0, m_be, m_wd, m_rd, m_err);
        exp_q.push_back('{rdata: m_rd, err: m_err});
        @(negedge clk);
        req_load = 1'b1; req_addr = 32'h0000_7004;
        model(1'b1, 2'b11, 3'b000, 32'h0000_7004, 32'h1122_3344, 32'h0, m_be, m_wd, m_rd, m_err);
        nresp = 0; ready_at = 0; b_at = 0;
        for (int i = 1; i <= 8; i++) begin
            if (bus_req) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'h5555_AAAA;
            end
            if (resp_valid) begin
                nresp++;
                pop_check("b2b");
                if (nresp == 2) b_at = i;
            end
            if (req_ready && req_valid) begin
                ready_at = i;
                exp_q.push_back('{rdata: m_rd, err: m_err});
            end
            @(negedge clk);
            bus_ack = 1'b0;
            if (ready_at != 0) req_valid = 1'b0;
        end
        check("b2b_second_accept_cycle", 32'(ready_at), 32'd3);
        check("b2b_second_resp_cycle", 32'(b_at), 32'd4);
        check("b2b_resp_count", 32'(nresp), 32'd2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
